// File: rtl/fight_pkg.sv
// Shared definitions for the fighting game core and the match referee:
// widths, referee state encoding, winner codes and the health/score judge.
package fight_pkg;

    localparam int unsigned HEALTH_W = 3;
    localparam int unsigned LOC_W    = 4;
    localparam int unsigned TIMER_W  = 6;
    localparam int unsigned ROUND_W  = 3;
    localparam int unsigned SCORE_W  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StFight,
        StRoundEnd,
        StMatchOver
    } ref_state_e;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE  = 2'b00;
    localparam winner_t WIN_LEFT  = 2'b01;
    localparam winner_t WIN_RIGHT = 2'b10;
    localparam winner_t WIN_DRAW  = 2'b11;

    // A KO is just the extreme case of "higher value wins", so one compare
    // judges KOs, double KOs, timeouts and final score tallies alike.
    function automatic winner_t higher(input logic [HEALTH_W-1:0] a,
                                       input logic [HEALTH_W-1:0] b);
        if (a > b) begin
            return WIN_LEFT;
        end
        if (b > a) begin
            return WIN_RIGHT;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Round clock: a TICK_DIV prescaler feeding a 6-bit down counter that
// stops at zero. Load takes priority over enable.
module round_timer
    import fight_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] load_value,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        if (load) begin
            pre_d   = '0;
            count_d = load_value;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - TIMER_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/match_referee.sv
// Best-of-N match referee: runs the round clock, judges each round from
// player health, scores the match and resets the core between rounds.
module match_referee
    import fight_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 50,
    parameter int unsigned ROUND_TICKS   = 60,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_ROUNDS    = 5,
    parameter int unsigned PAUSE_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [HEALTH_W-1:0] left_player_health_in,
    input  logic [HEALTH_W-1:0] right_player_health_in,
    output logic                players_rst_n,
    output logic [TIMER_W-1:0]  round_timer_out,
    output logic [ROUND_W-1:0]  round_num_out,
    output logic [SCORE_W-1:0]  left_rounds_out,
    output logic [SCORE_W-1:0]  right_rounds_out,
    output logic                match_over_out,
    output logic [1:0]          winner_out
);

    localparam int unsigned PAUSE_W = $clog2(PAUSE_CYCLES + 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD  = PAUSE_W'(PAUSE_CYCLES);
    localparam logic [TIMER_W-1:0] TICKS_LOAD  = TIMER_W'(ROUND_TICKS);
    localparam logic [SCORE_W-1:0] WIN_SCORE   = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(MAX_ROUNDS);

    ref_state_e         state_q, state_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SCORE_W-1:0] left_q, left_d;
    logic [SCORE_W-1:0] right_q, right_d;
    winner_t            winner_q, winner_d;
    logic               prst_q;
    logic               over_q;

    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_zero;
    logic [TIMER_W-1:0] tmr_count;
    logic               round_over;
    winner_t            round_result;

    round_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_round_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .en        (tmr_en),
        .load_value(TICKS_LOAD),
        .count     (tmr_count),
        .zero      (tmr_zero)
    );

    assign round_over   = (left_player_health_in == '0) || (right_player_health_in == '0) ||
                          tmr_zero;
    assign round_result = higher(left_player_health_in, right_player_health_in);

    always_comb begin
        state_d  = state_q;
        pause_d  = pause_q;
        round_d  = round_q;
        left_d   = left_q;
        right_d  = right_q;
        winner_d = winner_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            StIdle, StMatchOver: begin
                if (start) begin
                    state_d  = StFight;
                    tmr_load = 1'b1;
                    round_d  = '0;
                    left_d   = '0;
                    right_d  = '0;
                    winner_d = WIN_NONE;
                end
            end
            StFight: begin
                if (round_over) begin
                    state_d = StRoundEnd;
                    pause_d = PAUSE_LOAD;
                    if (round_q != {ROUND_W{1'b1}}) begin
                        round_d = round_q + ROUND_W'(1);
                    end
                    if (round_result == WIN_LEFT) begin
                        left_d = left_q + SCORE_W'(1);
                    end else if (round_result == WIN_RIGHT) begin
                        right_d = right_q + SCORE_W'(1);
                    end
                end else begin
                    // Timer is frozen on the deciding cycle so it shows the time of the finish.
                    tmr_en = 1'b1;
                end
            end
            StRoundEnd: begin
                if (pause_q <= PAUSE_W'(1)) begin
                    if (left_q == WIN_SCORE) begin
                        state_d  = StMatchOver;
                        winner_d = WIN_LEFT;
                    end else if (right_q == WIN_SCORE) begin
                        state_d  = StMatchOver;
                        winner_d = WIN_RIGHT;
                    end else if (round_q >= ROUND_LIMIT) begin
                        state_d  = StMatchOver;
                        winner_d = higher(HEALTH_W'(left_q), HEALTH_W'(right_q));
                    end else begin
                        state_d  = StFight;
                        tmr_load = 1'b1;
                    end
                end else begin
                    pause_d = pause_q - PAUSE_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pause_q  <= '0;
            round_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            winner_q <= WIN_NONE;
            prst_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pause_q  <= pause_d;
            round_q  <= round_d;
            left_q   <= left_d;
            right_q  <= right_d;
            winner_q <= winner_d;
            prst_q   <= (state_d == StFight);
            over_q   <= (state_d == StMatchOver);
        end
    end

    assign players_rst_n    = prst_q;
    assign round_timer_out  = tmr_count;
    assign round_num_out    = round_q;
    assign left_rounds_out  = left_q;
    assign right_rounds_out = right_q;
    assign match_over_out   = over_q;
    assign winner_out       = winner_q;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: directed rounds push expected score records into a
// queue; a monitor pops one each time the score/round/winner outputs change.
module tb_match_referee;
    import fight_pkg::*;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned ROUND_TICKS   = 5;
    localparam int unsigned ROUNDS_TO_WIN = 2;
    localparam int unsigned MAX_ROUNDS    = 5;
    localparam int unsigned PAUSE_CYCLES  = 3;

    typedef struct packed {
        logic [2:0] rn;
        logic [1:0] lw;
        logic [1:0] rw;
        logic       mo;
        logic [1:0] win;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] lh = 3'd7;
    logic [2:0] rh = 3'd7;

    logic       players_rst_n;
    logic [5:0] round_timer_out;
    logic [2:0] round_num_out;
    logic [1:0] left_rounds_out;
    logic [1:0] right_rounds_out;
    logic       match_over_out;
    logic [1:0] winner_out;

    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    match_referee #(
        .TICK_DIV     (TICK_DIV),
        .ROUND_TICKS  (ROUND_TICKS),
        .ROUNDS_TO_WIN(ROUNDS_TO_WIN),
        .MAX_ROUNDS   (MAX_ROUNDS),
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .left_player_health_in (lh),
        .right_player_health_in(rh),
        .players_rst_n         (players_rst_n),
        .round_timer_out       (round_timer_out),
        .round_num_out         (round_num_out),
        .left_rounds_out       (left_rounds_out),
        .right_rounds_out      (right_rounds_out),
        .match_over_out        (match_over_out),
        .winner_out            (winner_out)
    );

    function automatic rec_t mk(input int rn, input int lw, input int rw, input int mo,
                                input int win);
        rec_t r;
        r.rn  = 3'(rn);
        r.lw  = 2'(lw);
        r.rw  = 2'(rw);
        r.mo  = 1'(mo);
        r.win = 2'(win);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every change of the scoring outputs is one DUT event.
    initial begin
        rec_t prev;
        rec_t cur;
        rec_t e;
        prev = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = {round_num_out, left_rounds_out, right_rounds_out, match_over_out, winner_out};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_score_change: got %h expected no change", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("score_record{rn,lw,rw,mo,win}", 32'(cur), 32'(e));
                end
                prev = cur;
            end
        end
    end

    task automatic wait_timer(input int val, input string name);
        int n = 0;
        while (round_timer_out !== 6'(val) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(round_timer_out), 32'(val));
    endtask

    // Called on the negedge before the deciding edge; checks the hold and its exit.
    task automatic pause_check(input bit cont, input int exp_tmr);
        for (int i = 0; i < int'(PAUSE_CYCLES); i++) begin
            @(negedge clk);
            lh = 3'd7;
            rh = 3'd7;
            chk("pause_players_rst_n", 32'(players_rst_n), 32'd0);
            chk("pause_timer_frozen", 32'(round_timer_out), 32'(exp_tmr));
        end
        @(negedge clk);
        if (cont) begin
            chk("resume_players_rst_n", 32'(players_rst_n), 32'd1);
            chk("resume_timer_reload", 32'(round_timer_out), 32'(ROUND_TICKS));
        end else begin
            chk("over_players_rst_n", 32'(players_rst_n), 32'd0);
            chk("over_match_over", 32'(match_over_out), 32'd1);
        end
    endtask

    task automatic ko_round(input int l, input int r, input int exp_tmr, input rec_t res,
                            input bit cont, input rec_t fin);
        exp_q.push_back(res);
        if (!cont) exp_q.push_back(fin);
        lh = 3'(l);
        rh = 3'(r);
        pause_check(cont, exp_tmr);
    endtask

    task automatic timeout_round(input int l, input int r, input int late_l, input int late_r,
                                 input rec_t res, input bit cont, input rec_t fin);
        exp_q.push_back(res);
        if (!cont) exp_q.push_back(fin);
        lh = 3'(l);
        rh = 3'(r);
        wait_timer(0, "timeout_timer_zero");
        lh = 3'(late_l);
        rh = 3'(late_r);
        pause_check(cont, 0);
    endtask

    task automatic begin_match(input bit from_over);
        if (from_over) exp_q.push_back(mk(0, 0, 0, 0, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_players_rst_n", 32'(players_rst_n), 32'd1);
        chk("start_timer", 32'(round_timer_out), 32'(ROUND_TICKS));
    endtask

    initial begin
        rec_t z;
        z = mk(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_players_rst_n", 32'(players_rst_n), 32'd0);
        chk("reset_timer", 32'(round_timer_out), 32'd0);
        chk("reset_round_num", 32'(round_num_out), 32'd0);
        chk("reset_left_rounds", 32'(left_rounds_out), 32'd0);
        chk("reset_right_rounds", 32'(right_rounds_out), 32'd0);
        chk("reset_match_over", 32'(match_over_out), 32'd0);
        chk("reset_winner", 32'(winner_out), 32'(WIN_NONE));
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_players_rst_n", 32'(players_rst_n), 32'd0);

        // Match A: left KOs right twice.
        begin_match(1'b0);
        repeat (3) @(negedge clk);
        chk("timer_before_tick", 32'(round_timer_out), 32'd5);
        @(negedge clk);
        chk("timer_first_tick", 32'(round_timer_out), 32'd4);
        ko_round(7, 0, 4, mk(1, 1, 0, 0, 0), 1'b1, z);
        ko_round(7, 0, 5, mk(2, 2, 0, 0, 0), 1'b0, mk(2, 2, 0, 1, 1));
        chk("match_a_winner", 32'(winner_out), 32'(WIN_LEFT));
        begin_match(1'b1);
        chk("restart_winner_cleared", 32'(winner_out), 32'(WIN_NONE));

        // Match B: timeouts, double KO, right takes it; start held during a round is ignored.
        start = 1'b1;
        timeout_round(3, 5, 3, 5, mk(1, 0, 1, 0, 0), 1'b1, z);
        start = 1'b0;
        timeout_round(4, 4, 4, 4, mk(2, 0, 1, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(3, 0, 1, 0, 0), 1'b1, z);
        ko_round(0, 7, 5, mk(4, 0, 2, 0, 0), 1'b0, mk(4, 0, 2, 1, 2));
        chk("match_b_winner", 32'(winner_out), 32'(WIN_RIGHT));
        begin_match(1'b1);

        // Match C: five draws.
        ko_round(0, 0, 5, mk(1, 0, 0, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(2, 0, 0, 0, 0), 1'b1, z);
        timeout_round(2, 2, 2, 2, mk(3, 0, 0, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(4, 0, 0, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(5, 0, 0, 0, 0), 1'b0, mk(5, 0, 0, 1, 3));
        chk("match_c_winner", 32'(winner_out), 32'(WIN_DRAW));
        begin_match(1'b1);

        // Match D: 1-1 then three draws.
        ko_round(7, 0, 5, mk(1, 1, 0, 0, 0), 1'b1, z);
        ko_round(0, 7, 5, mk(2, 1, 1, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(3, 1, 1, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(4, 1, 1, 0, 0), 1'b1, z);
        ko_round(0, 0, 5, mk(5, 1, 1, 0, 0), 1'b0, mk(5, 1, 1, 1, 3));
        chk("match_d_winner", 32'(winner_out), 32'(WIN_DRAW));
        begin_match(1'b1);

        // Match E: KO on the timeout cycle, then reset mid-round at 1-0.
        timeout_round(7, 7, 7, 0, mk(1, 1, 0, 0, 0), 1'b1, z);
        wait_timer(2, "timer_reaches_2");
        exp_q.push_back(z);
        rst_n = 1'b0;
        #1;
        chk("midreset_players_rst_n", 32'(players_rst_n), 32'd0);
        chk("midreset_timer", 32'(round_timer_out), 32'd0);
        chk("midreset_round_num", 32'(round_num_out), 32'd0);
        chk("midreset_left_rounds", 32'(left_rounds_out), 32'd0);
        chk("midreset_right_rounds", 32'(right_rounds_out), 32'd0);
        chk("midreset_match_over", 32'(match_over_out), 32'd0);
        chk("midreset_winner", 32'(winner_out), 32'(WIN_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_players_rst_n", 32'(players_rst_n), 32'd0);
        chk("idle_after_reset_timer", 32'(round_timer_out), 32'd0);
        begin_match(1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

endmodule
